// File: rtl/serdes_pkg.sv
// Shared types and helpers for the serdes serializer slice.
package serdes_pkg;

  typedef enum logic {IDLE, SEND} serdes_ser_state_t;

  // Counter width for an n-entry index; never narrower than one bit.
  function automatic int cnt_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/serdes_serializer_ctrl.sv
// Serializer control: IDLE/SEND FSM plus word index counter.
module serdes_serializer_ctrl
  import serdes_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  parameter int CW        = cnt_width(N_SAMPLES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          recv_val,
  input  logic          send_rdy,
  output logic          recv_rdy,
  output logic          send_val,
  output logic          load,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] LAST_IDX = CW'(N_SAMPLES - 1);
  localparam logic [CW-1:0] ONE_IDX  = CW'(1);

  serdes_ser_state_t state_r, state_next_s;
  logic [CW-1:0]     count_r, count_next_s;
  logic              recv_rdy_s, send_val_s, load_s;

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      count_r <= '0;
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
    end
  end

  // Next-state and handshake decode; the last beat reopens recv_rdy in the same cycle.
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    recv_rdy_s   = 1'b0;
    send_val_s   = 1'b0;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        recv_rdy_s = 1'b1;
        if (recv_val) begin
          load_s       = 1'b1;
          count_next_s = '0;
          state_next_s = SEND;
        end else begin
          state_next_s = IDLE;
        end
      end
      SEND: begin
        send_val_s = 1'b1;
        if (send_rdy) begin
          if (count_r == LAST_IDX) begin
            recv_rdy_s   = 1'b1;
            count_next_s = '0;
            if (recv_val) begin
              load_s       = 1'b1;
              state_next_s = SEND;
            end else begin
              state_next_s = IDLE;
            end
          end else begin
            count_next_s = count_r + ONE_IDX;
          end
        end else begin
          count_next_s = count_r;
        end
      end
      default: begin
        state_next_s = IDLE;
        count_next_s = '0;
      end
    endcase
  end

  assign recv_rdy = recv_rdy_s & reset;
  assign send_val = send_val_s & reset;
  assign load     = load_s & reset;
  assign count    = count_r;

endmodule

// File: rtl/serdes_serializer.sv
// Parallel-to-serial stage: takes one N_SAMPLES-word frame, emits words index 0 first.
module serdes_serializer
  import serdes_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  input  logic [BIT_WIDTH-1:0] recv_msg [N_SAMPLES],
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic [BIT_WIDTH-1:0] send_msg
);

  generate
    if (N_SAMPLES == 1) begin : g_bypass
      logic unused_clk_rst_s;
      assign unused_clk_rst_s = clk ^ reset;
      assign recv_rdy = send_rdy;
      assign send_val = recv_val;
      assign send_msg = recv_msg[0];
    end else begin : g_ser
      localparam int CW = cnt_width(N_SAMPLES);

      logic                 load_s;
      logic                 send_val_s;
      logic [CW-1:0]        count_s;
      logic [BIT_WIDTH-1:0] frame_r [N_SAMPLES];

      serdes_serializer_ctrl #(
        .N_SAMPLES (N_SAMPLES),
        .CW        (CW)
      ) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .recv_val (recv_val),
        .send_rdy (send_rdy),
        .recv_rdy (recv_rdy),
        .send_val (send_val_s),
        .load     (load_s),
        .count    (count_s)
      );

      for (genvar i = 0; i < N_SAMPLES; i++) begin : g_word
        // Frame word register, written only on an accepted frame.
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            frame_r[i] <= '0;
          end else if (load_s) begin
            frame_r[i] <= recv_msg[i];
          end else begin
            frame_r[i] <= frame_r[i];
          end
        end
      end

      assign send_val = send_val_s;
      assign send_msg = send_val_s ? frame_r[count_s] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_serdes_serializer.sv
// Directed bench for serdes_serializer at N=4, N=3 and N=1 (all W=8).
module tb_serdes_serializer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       rv4 = 1'b0, rr4, sv4, sr4 = 1'b0;
  logic [7:0] rm4 [4];
  logic [7:0] sm4;
  logic       rv3 = 1'b0, rr3, sv3, sr3 = 1'b0;
  logic [7:0] rm3 [3];
  logic [7:0] sm3;
  logic       rv1 = 1'b0, rr1, sv1, sr1 = 1'b0;
  logic [7:0] rm1 [1];
  logic [7:0] sm1;

  int checks = 0;
  int failures = 0;

  serdes_serializer #(.N_SAMPLES(4), .BIT_WIDTH(8)) dut4 (
    .clk(clk), .reset(reset), .recv_val(rv4), .recv_rdy(rr4), .recv_msg(rm4),
    .send_val(sv4), .send_rdy(sr4), .send_msg(sm4));
  serdes_serializer #(.N_SAMPLES(3), .BIT_WIDTH(8)) dut3 (
    .clk(clk), .reset(reset), .recv_val(rv3), .recv_rdy(rr3), .recv_msg(rm3),
    .send_val(sv3), .send_rdy(sr3), .send_msg(sm3));
  serdes_serializer #(.N_SAMPLES(1), .BIT_WIDTH(8)) dut1 (
    .clk(clk), .reset(reset), .recv_val(rv1), .recv_rdy(rr1), .recv_msg(rm1),
    .send_val(sv1), .send_rdy(sr1), .send_msg(sm1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rv4 = 1'b1;
    rm4[0] = 8'h99; rm4[1] = 8'h98; rm4[2] = 8'h97; rm4[3] = 8'h96;
    sr4 = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (rr4 !== 1'b0 || sv4 !== 1'b0 || sm4 !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b val=%b msg=%h expected 0 0 00", rr4, sv4, sm4);
    end
    rv4 = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (rr4 !== 1'b1 || sv4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got rdy=%b val=%b expected 1 0", rr4, sv4);
    end
    step();
    step();
    checks++;
    if (rr4 !== 1'b1 || sv4 !== 1'b0 || sm4 !== 8'h00) begin
      failures++;
      $display("FAIL idle_hold: got rdy=%b val=%b msg=%h expected 1 0 00", rr4, sv4, sm4);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_w [4];
    exp_w[0] = 8'h11; exp_w[1] = 8'h22; exp_w[2] = 8'h33; exp_w[3] = 8'h44;
    rm4 = exp_w;
    rv4 = 1'b1;
    sr4 = 1'b1;
    step();
    rv4 = 1'b0;
    rm4[0] = 8'hEE; rm4[1] = 8'hEE; rm4[2] = 8'hEE; rm4[3] = 8'hEE;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sv4 !== 1'b1 || sm4 !== exp_w[i] || rr4 !== (i == 3)) begin
        failures++;
        $display("FAIL basic_word%0d: got val=%b msg=%h rdy=%b expected 1 %h %b",
                 i, sv4, sm4, rr4, exp_w[i], (i == 3));
      end
      step();
    end
    checks++;
    if (sv4 !== 1'b0 || rr4 !== 1'b1 || sm4 !== 8'h00) begin
      failures++;
      $display("FAIL basic_idle: got val=%b rdy=%b msg=%h expected 0 1 00", sv4, rr4, sm4);
    end
  endtask

  task automatic test_backpressure();
    rm4[0] = 8'h11; rm4[1] = 8'h22; rm4[2] = 8'h33; rm4[3] = 8'h44;
    rv4 = 1'b1;
    sr4 = 1'b1;
    step();
    rv4 = 1'b0;
    step();
    sr4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (sv4 !== 1'b1 || sm4 !== 8'h22 || rr4 !== 1'b0) begin
        failures++;
        $display("FAIL stall%0d: got val=%b msg=%h rdy=%b expected 1 22 0", i, sv4, sm4, rr4);
      end
    end
    sr4 = 1'b1;
    step();
    checks++;
    if (sv4 !== 1'b1 || sm4 !== 8'h33) begin
      failures++;
      $display("FAIL resume33: got val=%b msg=%h expected 1 33", sv4, sm4);
    end
    step();
    checks++;
    if (sv4 !== 1'b1 || sm4 !== 8'h44 || rr4 !== 1'b1) begin
      failures++;
      $display("FAIL resume44: got val=%b msg=%h rdy=%b expected 1 44 1", sv4, sm4, rr4);
    end
    step();
    checks++;
    if (sv4 !== 1'b0) begin
      failures++;
      $display("FAIL bp_idle: got val=%b expected 0", sv4);
    end
  endtask

  task automatic test_back_to_back();
    rm4[0] = 8'h01; rm4[1] = 8'h02; rm4[2] = 8'h03; rm4[3] = 8'h04;
    rv4 = 1'b1;
    sr4 = 1'b1;
    step();
    rm4[0] = 8'h05; rm4[1] = 8'h06; rm4[2] = 8'h07; rm4[3] = 8'h08;
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sv4 !== 1'b1 || sm4 !== 8'(i + 1) || rr4 !== (i == 3 || i == 7)) begin
        failures++;
        $display("FAIL b2b_word%0d: got val=%b msg=%h rdy=%b expected 1 %h %b",
                 i, sv4, sm4, rr4, 8'(i + 1), (i == 3 || i == 7));
      end
      if (i == 4) rv4 = 1'b0;
      step();
    end
    checks++;
    if (sv4 !== 1'b0 || rr4 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_idle: got val=%b rdy=%b expected 0 1", sv4, rr4);
    end
  endtask

  task automatic test_reset_mid_frame();
    rm4[0] = 8'h11; rm4[1] = 8'h22; rm4[2] = 8'h33; rm4[3] = 8'h44;
    rv4 = 1'b1;
    sr4 = 1'b1;
    step();
    rv4 = 1'b0;
    step();
    checks++;
    if (sm4 !== 8'h22) begin
      failures++;
      $display("FAIL mid_pre: got msg=%h expected 22", sm4);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (sv4 !== 1'b0 || sm4 !== 8'h00 || rr4 !== 1'b0) begin
      failures++;
      $display("FAIL mid_async: got val=%b msg=%h rdy=%b expected 0 00 0", sv4, sm4, rr4);
    end
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (sv4 !== 1'b0 || sm4 !== 8'h00) begin
        failures++;
        $display("FAIL mid_no_tail%0d: got val=%b msg=%h expected 0 00", i, sv4, sm4);
      end
    end
    rm4[0] = 8'h5A; rm4[1] = 8'h6B; rm4[2] = 8'h7C; rm4[3] = 8'h8D;
    rv4 = 1'b1;
    step();
    rv4 = 1'b0;
    checks++;
    if (sv4 !== 1'b1 || sm4 !== 8'h5A) begin
      failures++;
      $display("FAIL mid_next_word0: got val=%b msg=%h expected 1 5a", sv4, sm4);
    end
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_n3();
    logic [7:0] exp_w [6];
    exp_w[0] = 8'h0A; exp_w[1] = 8'h0B; exp_w[2] = 8'h0C;
    exp_w[3] = 8'h0D; exp_w[4] = 8'h0E; exp_w[5] = 8'h0F;
    rm3[0] = 8'h0A; rm3[1] = 8'h0B; rm3[2] = 8'h0C;
    rv3 = 1'b1;
    sr3 = 1'b1;
    step();
    rm3[0] = 8'h0D; rm3[1] = 8'h0E; rm3[2] = 8'h0F;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (sv3 !== 1'b1 || sm3 !== exp_w[i] || rr3 !== (i == 2 || i == 5)) begin
        failures++;
        $display("FAIL n3_word%0d: got val=%b msg=%h rdy=%b expected 1 %h %b",
                 i, sv3, sm3, rr3, exp_w[i], (i == 2 || i == 5));
      end
      if (i == 3) rv3 = 1'b0;
      step();
    end
    checks++;
    if (sv3 !== 1'b0 || rr3 !== 1'b1) begin
      failures++;
      $display("FAIL n3_idle: got val=%b rdy=%b expected 0 1", sv3, rr3);
    end
  endtask

  task automatic test_n1();
    rv1 = 1'b1;
    sr1 = 1'b0;
    rm1[0] = 8'h5C;
    #1;
    checks++;
    if (sv1 !== 1'b1 || sm1 !== 8'h5C || rr1 !== 1'b0) begin
      failures++;
      $display("FAIL n1_a: got val=%b msg=%h rdy=%b expected 1 5c 0", sv1, sm1, rr1);
    end
    rv1 = 1'b0;
    sr1 = 1'b1;
    rm1[0] = 8'hA3;
    #1;
    checks++;
    if (sv1 !== 1'b0 || sm1 !== 8'hA3 || rr1 !== 1'b1) begin
      failures++;
      $display("FAIL n1_b: got val=%b msg=%h rdy=%b expected 0 a3 1", sv1, sm1, rr1);
    end
  endtask

  initial begin
    rm3[0] = 8'h00; rm3[1] = 8'h00; rm3[2] = 8'h00;
    rm1[0] = 8'h00;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_n3();
    test_n1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
